// File: rtl/i2s_tx_slave.sv
// i2s_tx_slave
// I2S transmitter, slave mode. The codec supplies bclk and lrck; this block
// drives sdata. Stereo samples arrive over a valid/ready handshake into a
// one-pair holding buffer. Each channel word is serialised MSB-first, with the
// MSB on the wire one bclk after every lrck edge (standard I2S alignment).
//
// Build option:
//   I2S_TX_MUTE_ON_UNDERRUN_EN  defined     -> an underrun frame sends all-zero words
//                               not defined -> an underrun frame repeats the last
//                                              successfully transmitted L/R pair
module i2s_tx_slave #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  bclk,
  input  logic                  rst,
  input  logic                  lrck,
  input  logic [DATA_WIDTH-1:0] l_data,
  input  logic [DATA_WIDTH-1:0] r_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  sdata,
  output logic                  underrun
);

  // Bit counter only has to reach DATA_WIDTH-1.
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // The block ignores lrck until the first left-channel start after reset,
  // so that the first transmitted word is always a left word.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  state_t                  state_reg;
  logic                    last_lrck_reg;
  logic                    lrck_fall;
  logic                    lrck_rise;
  logic                    left_start;
  logic                    right_start;

  // Holding buffer: one L/R pair waiting for the next left start.
  logic                    hold_empty_reg;
  logic [DATA_WIDTH-1:0]   hold_l_reg;
  logic [DATA_WIDTH-1:0]   hold_r_reg;

  // Right word of the frame in flight, parked until the rising lrck edge.
  logic [DATA_WIDTH-1:0]   shadow_r_reg;

  // Serialiser.
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic [DATA_WIDTH-1:0]   shift_next;
  logic [CNT_W-1:0]        cnt_reg;
  logic                    sdata_reg;
  logic                    underrun_reg;

  // Words chosen for the frame that starts on this cycle.
  logic [DATA_WIDTH-1:0]   fill_l;
  logic [DATA_WIDTH-1:0]   fill_r;
  logic [DATA_WIDTH-1:0]   load_l;
  logic [DATA_WIDTH-1:0]   load_r;

  // lrck is sampled against its own previous value; a falling edge starts
  // the left channel, a rising edge starts the right channel.
  assign lrck_fall   = last_lrck_reg & ~lrck;
  assign lrck_rise   = ~last_lrck_reg & lrck;

  // A falling edge both arms the block and starts a frame, so it is never
  // gated by the armed state. Rising edges only count once armed.
  assign left_start  = lrck_fall;
  assign right_start = lrck_rise && (state_reg == ST_ARMED);

  assign shift_next  = shift_reg << 1;

  // Register lrck every cycle; reset copies the live level so the first
  // cycle after reset cannot see a false edge.
  always_ff @(posedge bclk) begin
    last_lrck_reg <= lrck;
  end

  // Arming state: idle after reset, armed from the first falling lrck edge.
  always_ff @(posedge bclk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else if (lrck_fall) begin
      state_reg <= ST_ARMED;
    end
  end

`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
  // Muted build: an underrun frame carries silence on both channels.
  assign fill_l = '0;
  assign fill_r = '0;
`else
  logic [DATA_WIDTH-1:0] last_l_reg;
  logic [DATA_WIDTH-1:0] last_r_reg;

  // Remember the pair most recently taken from the holding buffer so an
  // underrun frame can repeat it instead of clicking to silence.
  always_ff @(posedge bclk) begin
    if (rst) begin
      last_l_reg <= '0;
      last_r_reg <= '0;
    end else if (left_start && !hold_empty_reg) begin
      last_l_reg <= hold_l_reg;
      last_r_reg <= hold_r_reg;
    end
  end

  assign fill_l = last_l_reg;
  assign fill_r = last_r_reg;
`endif

  // Frame source: the buffered pair when there is one, otherwise the
  // underrun fill words.
  always_comb begin
    load_l = fill_l;
    load_r = fill_r;
    if (!hold_empty_reg) begin
      load_l = hold_l_reg;
      load_r = hold_r_reg;
    end
  end

  // Holding buffer and handshake. A left start empties a full buffer; a
  // write is only taken while empty, so a write landing on the same cycle
  // as an underrun left start is kept for the following frame.
  always_ff @(posedge bclk) begin
    if (rst) begin
      hold_empty_reg <= 1'b1;
      hold_l_reg     <= '0;
      hold_r_reg     <= '0;
    end else if (left_start && !hold_empty_reg) begin
      hold_empty_reg <= 1'b1;
    end else if (tx_valid && hold_empty_reg) begin
      hold_empty_reg <= 1'b0;
      hold_l_reg     <= l_data;
      hold_r_reg     <= r_data;
    end
  end

  // Park the right word of the frame that starts on this left edge.
  always_ff @(posedge bclk) begin
    if (rst) begin
      shadow_r_reg <= '0;
    end else if (left_start) begin
      shadow_r_reg <= load_r;
    end
  end

  // Serialiser: a channel start loads a word and drives its MSB at once;
  // the remaining bits follow on consecutive cycles, then the line idles at
  // 0. A new lrck edge always wins, truncating a word still in flight.
  always_ff @(posedge bclk) begin
    if (rst) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
      sdata_reg <= 1'b0;
    end else if (left_start) begin
      shift_reg <= load_l;
      cnt_reg   <= CNT_LAST;
      sdata_reg <= load_l[DATA_WIDTH-1];
    end else if (right_start) begin
      shift_reg <= shadow_r_reg;
      cnt_reg   <= CNT_LAST;
      sdata_reg <= shadow_r_reg[DATA_WIDTH-1];
    end else if (cnt_reg != '0) begin
      shift_reg <= shift_next;
      cnt_reg   <= cnt_reg - CNT_ONE;
      sdata_reg <= shift_next[DATA_WIDTH-1];
    end else begin
      sdata_reg <= 1'b0;
    end
  end

  // Sticky underrun: a frame started with nothing buffered.
  always_ff @(posedge bclk) begin
    if (rst) begin
      underrun_reg <= 1'b0;
    end else if (left_start && hold_empty_reg) begin
      underrun_reg <= 1'b1;
    end
  end

  assign tx_ready = hold_empty_reg;
  assign sdata    = sdata_reg;
  assign underrun = underrun_reg;

endmodule
